// File: rtl/nios_system2_cpu_ocimem_arbiter_pkg.sv
// nios_system2_cpu_ocimem_arbiter_pkg: shared constants, jdo field positions and FSM states for the OCI RAM arbiter
package nios_system2_cpu_ocimem_arbiter_pkg;
    localparam int ADDR_W_DEF   = 8;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    typedef enum logic [1:0] {IDLE, RD_AV, RD_JT} state_e;
endpackage

// File: rtl/nios_system2_cpu_ocimem_jtag_req.sv
// nios_system2_cpu_ocimem_jtag_req: pending JTAG request, auto-incrementing JTAG address and sticky overrun flag
module nios_system2_cpu_ocimem_jtag_req
    import nios_system2_cpu_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo_i,
    input  logic              act_a_i,
    input  logic              noact_a_i,
    input  logic              act_b_i,
    input  logic              issue_i,
    input  logic              done_i,
    output logic              pend_o,
    output logic              pend_wr_o,
    output logic [31:0]       pend_data_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic              jtag_busy_o,
    output logic              jtag_overrun_o
);
    logic              pend_q, pend_d, wr_q, wr_d, infl_q, infl_d, ovr_q, ovr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              strobe, busy, accept;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo_i[37:35], jdo_i[2:0]};

    // a request completing this cycle frees the slot, so a new strobe is accepted cleanly
    always_comb begin
        strobe = act_a_i | noact_a_i | act_b_i;
        busy   = (pend_q | infl_q) & ~done_i;
        accept = strobe & (~busy | (pend_q & ~issue_i));
        pend_d = accept | (pend_q & ~issue_i);
        wr_d   = accept ? act_b_i : wr_q;
        data_d = accept ? jdo_i[JDO_DATA_MSB:JDO_DATA_LSB] : data_q;
        infl_d = (issue_i & ~wr_q) | (infl_q & ~done_i);
        ovr_d  = ovr_q | (strobe & busy);
        addr_d = (accept & act_a_i) ? jdo_i[JDO_ADDR_LSB +: ADDR_W] :
                 done_i ? addr_q + ADDR_W'(1) : addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            wr_q   <= 1'b0;
            infl_q <= 1'b0;
            ovr_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            pend_q <= pend_d;
            wr_q   <= wr_d;
            infl_q <= infl_d;
            ovr_q  <= ovr_d;
            data_q <= data_d;
            addr_q <= addr_d;
        end
    end

    assign pend_o         = pend_q;
    assign pend_wr_o      = wr_q;
    assign pend_data_o    = data_q;
    assign jtag_addr_o    = addr_q;
    assign jtag_busy_o    = pend_q | infl_q;
    assign jtag_overrun_o = ovr_q;
endmodule

// File: rtl/nios_system2_cpu_ocimem_arbiter.sv
// nios_system2_cpu_ocimem_arbiter: round-robin arbiter of the OCI RAM between JTAG debug strobes and the Avalon debug slave
module nios_system2_cpu_ocimem_arbiter
    import nios_system2_cpu_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);
    state_e            state_q, state_d;
    logic              last_av_q, last_av_d, run_q;
    logic [31:0]       mon_q, mon_d, rd_q, rd_d;
    logic              pend, pend_wr;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] jtag_addr;
    logic              av_req, g_av, g_jt, wr_av, wr_jt;

    nios_system2_cpu_ocimem_jtag_req #(.ADDR_W(ADDR_W)) u_req (
        .clk            (clk),
        .reset_n        (reset_n),
        .jdo_i          (jdo),
        .act_a_i        (take_action_ocimem_a),
        .noact_a_i      (take_no_action_ocimem_a),
        .act_b_i        (take_action_ocimem_b),
        .issue_i        (g_jt),
        .done_i         (wr_jt | (state_q == RD_JT)),
        .pend_o         (pend),
        .pend_wr_o      (pend_wr),
        .pend_data_o    (pend_data),
        .jtag_addr_o    (jtag_addr),
        .jtag_busy_o    (jtag_busy),
        .jtag_overrun_o (jtag_overrun)
    );

    // run_q holds off grants for the first cycle after reset so no access leaks out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_av_q <= 1'b0;
            run_q     <= 1'b0;
            mon_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            last_av_q <= last_av_d;
            run_q     <= 1'b1;
            mon_q     <= mon_d;
            rd_q      <= rd_d;
        end
    end

    always_comb begin
        av_req    = run_q & (av_read | av_write);
        g_av      = (state_q == IDLE) & av_req & (~pend | ~last_av_q);
        g_jt      = (state_q == IDLE) & run_q & pend & ~g_av;
        wr_av     = g_av & av_write;
        wr_jt     = g_jt & pend_wr;
        state_d   = (g_av & ~av_write) ? RD_AV : (g_jt & ~pend_wr) ? RD_JT : IDLE;
        last_av_d = g_av | (last_av_q & ~g_jt);
        mon_d     = wr_jt ? pend_data : (state_q == RD_JT) ? ram_rdata : mon_q;
        rd_d      = (state_q == RD_AV) ? ram_rdata : rd_q;
    end

    always_comb begin
        ram_wren       = wr_av | wr_jt;
        ram_addr       = g_av ? av_address : jtag_addr;
        ram_byteenable = wr_av ? av_byteenable : wr_jt ? 4'hF : 4'h0;
        ram_wdata      = wr_av ? av_writedata : wr_jt ? pend_data : 32'h0;
        av_waitrequest = ~(wr_av | (state_q == RD_AV));
        av_readdata    = (state_q == RD_AV) ? ram_rdata : rd_q;
    end

    assign MonDReg = mon_q;
endmodule

// File: tb/tb_nios_system2_cpu_ocimem_arbiter.sv
// tb_nios_system2_cpu_ocimem_arbiter: directed and randomized checks of the OCI RAM arbiter against a transaction-level memory model
module tb_nios_system2_cpu_ocimem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [37:0]   jdo = '0;
    logic          act_a = 1'b0, noact_a = 1'b0, act_b = 1'b0;
    logic [AW-1:0] av_address = '0;
    logic          av_read = 1'b0, av_write = 1'b0;
    logic [31:0]   av_writedata = '0;
    logic [3:0]    av_byteenable = '0;
    logic [31:0]   av_readdata;
    logic          av_waitrequest;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [3:0]    ram_byteenable;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [31:0]   MonDReg;
    logic          jtag_busy, jtag_overrun;

    logic [31:0]   ram [256];
    bit [255:0]    written;
    bit [31:0]     ref_mem [256];
    int            wr_cnt;
    logic [AW-1:0] lw_addr;
    logic [3:0]    lw_be;
    logic [31:0]   lw_data;
    int            errors = 0, checks = 0;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_mon;
    logic          exp_ovr;

    always #5 clk = ~clk;

    nios_system2_cpu_ocimem_arbiter #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (act_a),
        .take_no_action_ocimem_a (noact_a),
        .take_action_ocimem_b    (act_b),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {a, ~a, a ^ 8'h3C, 8'h99};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // synchronous single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        ram_rdata <= written[ram_addr] ? ram[ram_addr] : init_word(ram_addr);
        if (ram_wren) begin
            ram[ram_addr]     <= merge(written[ram_addr] ? ram[ram_addr] : init_word(ram_addr), ram_wdata, ram_byteenable);
            written[ram_addr] <= 1'b1;
            wr_cnt            <= wr_cnt + 1;
            lw_addr           <= ram_addr;
            lw_be             <= ram_byteenable;
            lw_data           <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic jt_strobe(input int kind, input logic [37:0] d);
        @(negedge clk);
        jdo = d;
        act_a = (kind == 0);
        noact_a = (kind == 1);
        act_b = (kind == 2);
        @(negedge clk);
        act_a = 1'b0;
        noact_a = 1'b0;
        act_b = 1'b0;
    endtask

    task automatic jt_wait(output int cyc);
        cyc = 0;
        while (jtag_busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("jtag_done", jtag_busy, 0);
    endtask

    // kind 0: load address + read, 1: read at current address, 2: write
    task automatic jt_op(input int kind, input logic [31:0] val);
        logic [37:0] d;
        int cyc;
        d = '0;
        if (kind == 0) d[24:17] = val[7:0];
        else d[34:3] = val;
        jt_strobe(kind, d);
        jt_wait(cyc);
        if (kind == 0) exp_addr = val[7:0];
        if (kind == 2) begin
            ref_mem[exp_addr] = val;
            exp_mon = val;
            chk("jt_wr_mon", MonDReg, exp_mon);
            chk("jt_wr_latency", cyc, 1);
        end else begin
            exp_mon = ref_mem[exp_addr];
            chk("jt_rd_mon", MonDReg, exp_mon);
            chk("jt_rd_latency", cyc, 2);
        end
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        int cyc;
        cyc = 0;
        @(negedge clk);
        av_address = a;
        av_writedata = d;
        av_byteenable = be;
        av_write = 1'b1;
        #1;
        while (av_waitrequest && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("av_wr_wait", cyc, 0);
        chk("av_wr_wren", ram_wren, 1);
        chk("av_wr_be", ram_byteenable, be);
        @(negedge clk);
        av_write = 1'b0;
        ref_mem[a] = merge(ref_mem[a], d, be);
    endtask

    task automatic av_rd(input logic [7:0] a);
        int cyc;
        cyc = 0;
        @(negedge clk);
        av_address = a;
        av_read = 1'b1;
        #1;
        while (av_waitrequest && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("av_rd_data", av_readdata, ref_mem[a]);
        chk("av_rd_wait", cyc, 1);
        @(negedge clk);
        av_read = 1'b0;
        #1;
        chk("av_rd_hold", av_readdata, ref_mem[a]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_addr = '0;
        exp_mon = '0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        int cyc, wc, op;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        exp_addr = '0;
        exp_mon = '0;
        exp_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mon", MonDReg, 0);
        chk("rst_av_rdata", av_readdata, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_be", ram_byteenable, 0);
        chk("rst_waitreq", av_waitrequest, 1);
        chk("rst_busy", jtag_busy, 0);
        chk("rst_overrun", jtag_overrun, 0);
        chk("rst_addr", ram_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        jt_op(0, 32'h10);
        chk("t1_mon", MonDReg, 32'hDEADBEEF);
        jt_op(1, 0);

        jt_op(0, 32'hFE);
        jt_op(2, 32'h12345678);
        chk("t2_lw_addr", lw_addr, 8'hFF);
        chk("t2_lw_be", lw_be, 4'hF);
        chk("t2_lw_data", lw_data, 32'h12345678);
        jt_op(1, 0);

        av_wr(8'h05, 32'hA5A5A5A5, 4'b0011);
        chk("t3_lw_be", lw_be, 4'b0011);
        av_rd(8'h05);
        chk("t3_merged", ref_mem[5], {init_word(8'h05)[31:16], 16'hA5A5});

        do_reset();
        @(negedge clk);
        jdo = '0;
        noact_a = 1'b1;
        @(negedge clk);
        noact_a = 1'b0;
        av_address = 8'h20;
        av_read = 1'b1;
        #1;
        chk("c1_av_first", ram_addr, 8'h20);
        chk("c1_av_wait", av_waitrequest, 1);
        @(negedge clk);
        #1;
        chk("c1_av_ready", av_waitrequest, 0);
        chk("c1_av_data", av_readdata, ref_mem[8'h20]);
        av_read = 1'b0;
        @(negedge clk);
        #1;
        chk("c1_jt_busy", jtag_busy, 1);
        chk("c1_jt_addr", ram_addr, exp_addr);
        jt_wait(cyc);
        exp_mon = ref_mem[exp_addr];
        exp_addr = exp_addr + 1'b1;
        chk("c1_jt_mon", MonDReg, exp_mon);

        @(negedge clk);
        noact_a = 1'b1;
        @(negedge clk);
        noact_a = 1'b0;
        av_address = 8'h30;
        av_read = 1'b1;
        #1;
        chk("c2_av_first", ram_addr, 8'h30);
        @(negedge clk);
        #1;
        chk("c2_av_data", av_readdata, ref_mem[8'h30]);
        av_read = 1'b0;
        jt_wait(cyc);
        exp_mon = ref_mem[exp_addr];
        exp_addr = exp_addr + 1'b1;
        chk("c2_jt_mon", MonDReg, exp_mon);

        @(negedge clk);
        av_address = 8'h60;
        av_read = 1'b1;
        jdo = '0;
        jdo[24:17] = 8'h40;
        act_a = 1'b1;
        #1;
        chk("ov_av_first", ram_addr, 8'h60);
        @(negedge clk);
        jdo[24:17] = 8'h50;
        #1;
        chk("ov_av_data", av_readdata, ref_mem[8'h60]);
        av_read = 1'b0;
        @(negedge clk);
        act_a = 1'b0;
        #1;
        chk("ov_flag", jtag_overrun, 1);
        chk("ov_second_addr", ram_addr, 8'h50);
        jt_wait(cyc);
        exp_ovr = 1'b1;
        exp_addr = 8'h51;
        chk("ov_mon", MonDReg, ref_mem[8'h50]);
        jt_op(1, 0);
        chk("ov_sticky", jtag_overrun, 1);

        wc = wr_cnt;
        jt_strobe(0, {13'h0, 8'h70, 17'h0});
        @(negedge clk);
        #1;
        chk("mr_busy_rdjt", jtag_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_mon", MonDReg, 0);
        chk("mr_busy", jtag_busy, 0);
        chk("mr_overrun", jtag_overrun, 0);
        chk("mr_waitreq", av_waitrequest, 1);
        chk("mr_wren", ram_wren, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_no_write", wr_cnt, wc);
        chk("mr_idle_busy", jtag_busy, 0);
        chk("mr_idle_waitreq", av_waitrequest, 1);
        exp_addr = '0;
        exp_mon = '0;
        exp_ovr = 1'b0;

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: jt_op(0, $urandom_range(0, 255));
                1: jt_op(1, 0);
                2: jt_op(2, $urandom);
                3: av_wr(8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(1, 15)));
                default: av_rd(8'($urandom_range(0, 255)));
            endcase
            chk("rnd_overrun", jtag_overrun, exp_ovr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
